// File: rtl/alu_driver.sv
// Sequences one operation at a time through a registered ALU of fixed latency and
// holds the captured result on a valid/ready response port until it is consumed.
module alu_driver #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [WORD_SIZE-1:0] req_a,
    input  logic [WORD_SIZE-1:0] req_b,
    output logic [2:0]           alu_control,
    output logic [WORD_SIZE-1:0] alu_in_1,
    output logic [WORD_SIZE-1:0] alu_in_2,
    input  logic [WORD_SIZE-1:0] alu_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_data,
    output logic [2:0]           rsp_op,
    output logic                 busy,
    output logic [15:0]          op_count
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [2:0] LatCnt = 3'(ALU_LATENCY);

    state_e               state_q, state_d;
    logic [2:0]           wait_cnt_q;
    logic [2:0]           alu_control_q;
    logic [WORD_SIZE-1:0] alu_in_1_q;
    logic [WORD_SIZE-1:0] alu_in_2_q;
    logic [WORD_SIZE-1:0] rsp_data_q;
    logic [2:0]           rsp_op_q;
    logic [15:0]          op_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid) state_d = StWait;
            StWait:  if (wait_cnt_q == 3'd0) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // req_ready is forced low while reset is asserted, so nothing is accepted that edge.
    always_comb begin
        req_ready = (state_q == StIdle) && !reset;
        busy      = !req_ready;
        rsp_valid = (state_q == StResp);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q    <= 3'd0;
            alu_control_q <= 3'd0;
            alu_in_1_q    <= '0;
            alu_in_2_q    <= '0;
            rsp_data_q    <= '0;
            rsp_op_q      <= 3'd0;
            op_count_q    <= 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        alu_control_q <= req_op;
                        alu_in_1_q    <= req_a;
                        alu_in_2_q    <= req_b;
                        rsp_op_q      <= req_op;
                        wait_cnt_q    <= LatCnt;
                    end
                end
                StWait: begin
                    if (wait_cnt_q != 3'd0) begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end else begin
                        rsp_data_q <= alu_out;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        op_count_q <= op_count_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_control = alu_control_q;
    assign alu_in_1    = alu_in_1_q;
    assign alu_in_2    = alu_in_2_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_op      = rsp_op_q;
    assign op_count    = op_count_q;

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameter WORD_SIZE, default 32: data width of operands and result.
REQ-002 Parameter ALU_LATENCY, default 1, legal 1..4: cycles from the ALU sampling its inputs to `out` being valid.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  requester has an operation.
REQ-006 req_ready  output  1  block can accept an operation.
REQ-007 req_op  input  3  ALU control code (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra).
REQ-008 req_a, req_b  input  WORD_SIZE  signed operands.
REQ-009 alu_control  output  3  drives the ALU `control` port.
REQ-010 alu_in_1, alu_in_2  output  WORD_SIZE  drive the ALU `in_1` and `in_2` ports.
REQ-011 alu_out  input  WORD_SIZE  ALU registered result.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_data  output  WORD_SIZE  captured result.
REQ-015 rsp_op  output  3  op code of the result.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 op_count  output  16  number of completed response handshakes.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-019 req_ready SHALL be 1 in IDLE only, and 0 in every other state and during reset.
REQ-020 IDLE: on an edge with req_valid=1, req_op, req_a and req_b SHALL be registered onto alu_control, alu_in_1 and alu_in_2; rsp_op SHALL be registered with req_op; wait_cnt SHALL load ALU_LATENCY; next state SHALL be WAIT.
REQ-021 IDLE with req_valid=0: all registers SHALL hold.
REQ-022 alu_control, alu_in_1 and alu_in_2 SHALL stay stable from acceptance until the next acceptance or reset.
REQ-023 WAIT: at each edge with wait_cnt≠0, wait_cnt SHALL decrement.
REQ-024 WAIT: at the edge with wait_cnt=0, alu_out SHALL be captured into rsp_data and the next state SHALL be RESP.
REQ-025 rsp_valid SHALL rise on the edge that is ALU_LATENCY+1 edges after the accept edge.
REQ-026 rsp_valid SHALL be 1 exactly in RESP.
REQ-027 In RESP, rsp_data and rsp_op SHALL hold stable while rsp_ready=0, for any number of cycles.
REQ-028 RESP with rsp_ready=1 at an edge: the next state SHALL be IDLE and op_count SHALL increment by 1.
REQ-029 op_count SHALL wrap from 16'hFFFF to 0.
REQ-030 A new request SHALL NOT be accepted in the same cycle as a response handshake.
REQ-031 Minimum spacing between accepts SHALL be ALU_LATENCY+3 cycles.
REQ-032 rsp_data SHALL be passed through bit-exact, with no sign or width modification.
REQ-033 busy SHALL equal the inverse of req_ready.

Reset
REQ-034 On an edge with reset=1, the state SHALL become IDLE, and rsp_valid, rsp_data, rsp_op, alu_control, alu_in_1, alu_in_2, wait_cnt and op_count SHALL all become 0.
REQ-035 Reset in WAIT or RESP SHALL drop the in-flight operation with no response and no op_count increment.
REQ-036 Reset SHALL take priority over every other input in the same cycle.
REQ-037 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-038 The bench SHALL pair the DUT with a registered ALU model of configurable latency (shift amount in_2[4:0]) and cover at least these scenarios:
- add: op 000, a=9, b=11, L=1, rsp_ready=1 → rsp_data=20, rsp_op=000, rsp_valid rises 2 edges after accept, op_count=1.
- sub/and/or/xor: 001 with a=11, b=9 → 2; 010 with a=-1, b=0 → 0; 011 with a=-1, b=0 → 32'hFFFFFFFF; 100 with a=-1, b=-1 → 0. All SHALL be back-to-back with req_valid held high, accepts spaced exactly 4 cycles.
- shifts: a=30, b=5 → 101 gives 960, 110 gives 0, 111 gives 0; a=-64, b=2 with 111 → -16.
- backpressure: rsp_ready=0 for 5 cycles → rsp_valid, rsp_data and rsp_op stable; req_ready=0 throughout; op_count unchanged until rsp_ready=1.
- latency sweep: ALU_LATENCY=3, add 1+2 → rsp_valid 4 edges after accept, rsp_data=3.
- reset mid-op: reset asserted in WAIT → next cycle busy=0, rsp_valid=0, op_count=0; no response appears; the following request completes normally.
